// File: rtl/mem_bus_ctrl_pkg.sv
// rtl/mem_bus_ctrl_pkg.sv - shared types and constants for the data-bus controller
package mem_bus_ctrl_pkg;

    // Addresses at or above this value belong to the memory-mapped IO region
    localparam logic [31:0] IO_START_MEM = 32'hFFFF_FC00;

    // Cycles an IO access may stay outstanding before it is aborted
    localparam int IO_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAM_ACC,
        ST_RAM_DATA,
        ST_IO_ACC,
        ST_RESP
    } bus_state_e;

    typedef enum logic {
        OWN_CPU    = 1'b0,
        OWN_LOADER = 1'b1
    } owner_e;

    function automatic logic is_io(input logic [31:0] addr);
        return addr >= IO_START_MEM;
    endfunction

endpackage

// File: rtl/mem_bus_rr_arb.sv
// rtl/mem_bus_rr_arb.sv - two-way round-robin arbiter (bit0 = CPU, bit1 = loader)
module mem_bus_rr_arb
    import mem_bus_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    owner_e last_q;

    // On a tie the requester that did not win last time is granted
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_q == OWN_LOADER) ? 2'b01 : 2'b10;
        end
    end

    // Remember the winner only when the controller actually accepts a grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= OWN_LOADER;
        end else if (adv_i && (gnt_o != 2'b00)) begin
            last_q <= gnt_o[1] ? OWN_LOADER : OWN_CPU;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - multi-cycle data-bus controller for RAM and IO with CPU/loader sharing
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int IO_TIMEOUT = IO_TIMEOUT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_done_o,
    output logic        cpu_stall_o,
    input  logic        ld_req_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_wdata_i,
    output logic        ld_ack_o,
    output logic        ram_en_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    output logic        io_req_o,
    output logic        io_we_o,
    output logic [31:0] io_addr_o,
    output logic [31:0] io_wdata_o,
    input  logic [31:0] io_rdata_i,
    input  logic        io_ack_i,
    output logic        bus_err_o,
    input  logic        err_clr_i
);

    localparam int CW = (IO_TIMEOUT > 2) ? $clog2(IO_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(IO_TIMEOUT - 1);

    bus_state_e    state_q;
    owner_e        owner_q;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic          we_q;
    logic [CW-1:0] cnt_q;
    logic          ram_en_q, ram_we_q, io_req_q;
    logic          cpu_done_q, ld_ack_q, bus_err_q;

    logic [1:0]    gnt;
    logic [31:0]   sel_addr, sel_wdata;
    logic          sel_we;
    logic          err_set;

    mem_bus_rr_arb u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i ({ld_req_i, cpu_req_i}),
        .adv_i (state_q == ST_IDLE),
        .gnt_o (gnt)
    );

    // Mux the granted requester's fields; the loader only ever writes
    always_comb begin
        sel_addr  = gnt[1] ? ld_addr_i  : cpu_addr_i;
        sel_wdata = gnt[1] ? ld_wdata_i : cpu_wdata_i;
        sel_we    = gnt[1] | cpu_we_i;
        err_set   = ((state_q == ST_IDLE) && gnt[1] && is_io(ld_addr_i))
                 || ((state_q == ST_IO_ACC) && !io_ack_i && (cnt_q == TO_LAST));
    end

    // Access sequencer; every strobe is a flop set on entry to the state that owns it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_CPU;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            io_req_q   <= 1'b0;
            cpu_done_q <= 1'b0;
            ld_ack_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt != 2'b00) begin
                        owner_q <= gnt[1] ? OWN_LOADER : OWN_CPU;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        we_q    <= sel_we;
                        rdata_q <= '0;
                        cnt_q   <= '0;
                        if (!is_io(sel_addr)) begin
                            state_q  <= ST_RAM_ACC;
                            ram_en_q <= 1'b1;
                            ram_we_q <= sel_we;
                        end else if (gnt[1]) begin
                            state_q  <= ST_RESP;
                            ld_ack_q <= 1'b1;
                        end else begin
                            state_q  <= ST_IO_ACC;
                            io_req_q <= 1'b1;
                        end
                    end
                end
                ST_RAM_ACC: begin
                    ram_en_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    if (we_q) begin
                        state_q    <= ST_RESP;
                        cpu_done_q <= (owner_q == OWN_CPU);
                        ld_ack_q   <= (owner_q == OWN_LOADER);
                    end else begin
                        state_q <= ST_RAM_DATA;
                    end
                end
                ST_RAM_DATA: begin
                    rdata_q    <= ram_rdata_i;
                    state_q    <= ST_RESP;
                    cpu_done_q <= (owner_q == OWN_CPU);
                    ld_ack_q   <= (owner_q == OWN_LOADER);
                end
                ST_IO_ACC: begin
                    if (io_ack_i || (cnt_q == TO_LAST)) begin
                        io_req_q   <= 1'b0;
                        rdata_q    <= (io_ack_i && !we_q) ? io_rdata_i : '0;
                        state_q    <= ST_RESP;
                        cpu_done_q <= (owner_q == OWN_CPU);
                        ld_ack_q   <= (owner_q == OWN_LOADER);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    cpu_done_q <= 1'b0;
                    ld_ack_q   <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flag; a clear wins over a set in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_err_q <= 1'b0;
        end else if (err_clr_i) begin
            bus_err_q <= 1'b0;
        end else if (err_set) begin
            bus_err_q <= 1'b1;
        end
    end

    assign cpu_rdata_o = cpu_done_q ? rdata_q : '0;
    assign cpu_done_o  = cpu_done_q;
    assign cpu_stall_o = cpu_req_i & ~cpu_done_q;
    assign ld_ack_o    = ld_ack_q;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign io_req_o    = io_req_q;
    assign io_we_o     = io_req_q & we_q;
    assign io_addr_o   = addr_q;
    assign io_wdata_o  = wdata_q;
    assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - scoreboard bench for mem_bus_ctrl
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_done, cpu_stall;
    logic        ld_req;
    logic [31:0] ld_addr, ld_wdata;
    logic        ld_ack;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        io_req, io_we;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        io_ack;
    logic        bus_err, err_clr;

    typedef struct {
        logic        owner;   // 0 = CPU, 1 = loader
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_done_o  (cpu_done),
        .cpu_stall_o (cpu_stall),
        .ld_req_i    (ld_req),
        .ld_addr_i   (ld_addr),
        .ld_wdata_i  (ld_wdata),
        .ld_ack_o    (ld_ack),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .io_req_o    (io_req),
        .io_we_o     (io_we),
        .io_addr_o   (io_addr),
        .io_wdata_o  (io_wdata),
        .io_rdata_i  (io_rdata),
        .io_ack_i    (io_ack),
        .bus_err_o   (bus_err),
        .err_clr_i   (err_clr)
    );

    // Response monitor: pops the scoreboard on every completion pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_en && io_req) begin
                n_tests++; n_fail++;
                $display("FAIL strobe_excl: ram_en=%0b io_req=%0b, required not both", ram_en, io_req);
            end
            if (cpu_done || ld_ack) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_resp: cpu_done=%0b ld_ack=%0b, required none", cpu_done, ld_ack);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if ({ld_ack, cpu_done} !== (e.owner ? 2'b10 : 2'b01)) begin
                        n_fail++;
                        $display("FAIL resp_owner: ld_ack=%0b cpu_done=%0b, required owner %0d", ld_ack, cpu_done, e.owner);
                    end else if (!e.owner && cpu_rdata !== e.rdata) begin
                        n_fail++;
                        $display("FAIL resp_rdata: got %08h, required %08h", cpu_rdata, e.rdata);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic owner, input logic [31:0] rdata);
        exp_t e;
        e.owner = owner;
        e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0; ld_addr = 0; ld_wdata = 0; ram_rdata = 0; io_rdata = 0;
        io_ack = 0; err_clr = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({cpu_done, cpu_stall, ld_ack, ram_en, ram_we, io_req, io_we, bus_err} !== 8'b0 ||
            cpu_rdata !== 0 || ram_addr !== 0 || ram_wdata !== 0 || io_addr !== 0 || io_wdata !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: strobes=%b rdata=%08h addr=%08h, required all 0",
                     {cpu_done, cpu_stall, ld_ack, ram_en, ram_we, io_req, io_we, bus_err}, cpu_rdata, ram_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr[$];
        int resp = 0;
        exp_addr = '{32'h20, 32'h40, 32'h20, 32'h40};
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; ram_rdata = 32'h1111_2222;
        ld_req = 1; ld_addr = 32'h40; ld_wdata = 32'hA5A5_0001;
        push_exp(0, 32'h1111_2222); push_exp(1, 0);
        push_exp(0, 32'h1111_2222); push_exp(1, 0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ram_en) begin
                n_tests++;
                if (exp_addr.size() == 0 || ram_addr !== exp_addr[0]) begin
                    n_fail++;
                    $display("FAIL rr_order: ram_addr=%08h, required %08h", ram_addr,
                             exp_addr.size() ? exp_addr[0] : 32'hX);
                end else if (ram_we !== (exp_addr[0] == 32'h40)) begin
                    n_fail++;
                    $display("FAIL rr_we: ram_we=%0b for addr %08h", ram_we, ram_addr);
                end
                if (exp_addr.size()) void'(exp_addr.pop_front());
            end
            if (cpu_done || ld_ack) resp++;
            if (resp == 4) begin
                cpu_req = 0; ld_req = 0;
                break;
            end
        end
        n_tests++;
        if (resp != 4) begin
            n_fail++;
            $display("FAIL rr_timeout: %0d responses, required 4", resp);
            cpu_req = 0; ld_req = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_ram_load();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; ram_rdata = 32'hCAFE_F00D;
        push_exp(0, 32'hCAFE_F00D);
        #1;
        n_tests++;
        if (cpu_stall !== 1) begin n_fail++; $display("FAIL load_stall_T: got %0b, required 1", cpu_stall); end
        @(negedge clk);
        n_tests++;
        if (ram_en !== 1 || ram_we !== 0 || ram_addr !== 32'h10 || cpu_stall !== 1) begin
            n_fail++;
            $display("FAIL load_T1: ram_en=%0b ram_we=%0b addr=%08h stall=%0b, required 1 0 00000010 1",
                     ram_en, ram_we, ram_addr, cpu_stall);
        end
        @(negedge clk);
        n_tests++;
        if (ram_en !== 0 || cpu_done !== 0 || cpu_stall !== 1) begin
            n_fail++;
            $display("FAIL load_T2: ram_en=%0b done=%0b stall=%0b, required 0 0 1", ram_en, cpu_done, cpu_stall);
        end
        @(negedge clk);
        n_tests++;
        if (cpu_done !== 1 || cpu_stall !== 0) begin
            n_fail++;
            $display("FAIL load_T3: done=%0b stall=%0b, required 1 0", cpu_done, cpu_stall);
        end
        cpu_req = 0;
        @(negedge clk);
    endtask

    task automatic test_ram_store();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'h0BAD_BEEF;
        push_exp(0, 0);
        @(negedge clk);
        n_tests++;
        if (ram_we !== 1 || ram_wdata !== 32'h0BAD_BEEF || ram_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL store_T1: ram_we=%0b wdata=%08h addr=%08h, required 1 0badbeef 00000080",
                     ram_we, ram_wdata, ram_addr);
        end
        @(negedge clk);
        n_tests++;
        if (cpu_done !== 1) begin n_fail++; $display("FAIL store_T2: done=%0b, required 1", cpu_done); end
        cpu_req = 0;
        @(negedge clk);
    endtask

    task automatic test_io_store();
        logic bad = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'hFFFF_FC60; cpu_wdata = 32'h5A;
        push_exp(0, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (io_req !== 1 || io_we !== 1 || io_wdata !== 32'h5A || io_addr !== 32'hFFFF_FC60 || cpu_done !== 0)
                bad = 1;
            if (k == 4) io_ack = 1;
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL io_store_hold: io_req/io_we/io_wdata not held through ack, required 1/1/5a"); end
        @(negedge clk);
        io_ack = 0;
        n_tests++;
        if (cpu_done !== 1 || io_req !== 0) begin
            n_fail++;
            $display("FAIL io_store_done: done=%0b io_req=%0b, required 1 0", cpu_done, io_req);
        end
        cpu_req = 0;
        @(negedge clk);
    endtask

    task automatic test_io_load_fast();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hFFFF_FC04; io_rdata = 32'h1234_5678;
        push_exp(0, 32'h1234_5678);
        @(negedge clk);
        n_tests++;
        if (io_req !== 1 || io_we !== 0) begin
            n_fail++;
            $display("FAIL io_load_T1: io_req=%0b io_we=%0b, required 1 0", io_req, io_we);
        end
        io_ack = 1;
        @(negedge clk);
        io_ack = 0;
        n_tests++;
        if (cpu_done !== 1) begin n_fail++; $display("FAIL io_load_done: done=%0b, required 1", cpu_done); end
        cpu_req = 0;
        @(negedge clk);
    endtask

    task automatic test_io_timeout();
        logic bad = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hFFFF_FC10; io_rdata = 32'hDEAD_BEEF;
        push_exp(0, 0);
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            if (io_req !== 1 || cpu_done !== 0) bad = 1;
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL timeout_hold: io_req dropped or early done before T+256"); end
        @(negedge clk);
        n_tests++;
        if (cpu_done !== 1 || bus_err !== 1 || io_req !== 0) begin
            n_fail++;
            $display("FAIL timeout_done: done=%0b bus_err=%0b io_req=%0b, required 1 1 0", cpu_done, bus_err, io_req);
        end
        cpu_req = 0;
        @(negedge clk);
        io_ack = 1;
        @(negedge clk);
        io_ack = 0; err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        n_tests++;
        if (bus_err !== 0) begin n_fail++; $display("FAIL err_clr: bus_err=%0b, required 0", bus_err); end
    endtask

    task automatic test_loader_io();
        ld_req = 1; ld_addr = 32'hFFFF_FC00; ld_wdata = 32'h77;
        push_exp(1, 0);
        @(negedge clk);
        n_tests++;
        if (ld_ack !== 1 || io_req !== 0 || ram_en !== 0) begin
            n_fail++;
            $display("FAIL ld_io_T1: ld_ack=%0b io_req=%0b ram_en=%0b, required 1 0 0", ld_ack, io_req, ram_en);
        end
        ld_req = 0;
        @(negedge clk);
        n_tests++;
        if (bus_err !== 1) begin n_fail++; $display("FAIL ld_io_err: bus_err=%0b, required 1", bus_err); end
        err_clr = 1;
        @(negedge clk);
        ld_req = 1;
        push_exp(1, 0);
        @(negedge clk);
        ld_req = 0;
        @(negedge clk);
        err_clr = 0;
        n_tests++;
        if (bus_err !== 0) begin n_fail++; $display("FAIL err_clr_priority: bus_err=%0b, required 0", bus_err); end
    endtask

    task automatic test_reset_mid();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30; ram_rdata = 32'h3333_4444;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        n_tests++;
        if (ram_en !== 0 || io_req !== 0 || cpu_done !== 0 || cpu_rdata !== 0 || ram_addr !== 0) begin
            n_fail++;
            $display("FAIL reset_mid: ram_en=%0b io_req=%0b done=%0b rdata=%08h addr=%08h, required all 0",
                     ram_en, io_req, cpu_done, cpu_rdata, ram_addr);
        end
        cpu_req = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        n_tests++;
        if (cpu_done !== 0) begin n_fail++; $display("FAIL reset_no_done: done=%0b, required 0", cpu_done); end
        cpu_req = 1;
        push_exp(0, 32'h3333_4444);
        repeat (3) @(negedge clk);
        n_tests++;
        if (cpu_done !== 1) begin n_fail++; $display("FAIL reissue_done: done=%0b, required 1", cpu_done); end
        cpu_req = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_ram_load();
        test_ram_store();
        test_io_store();
        test_io_load_fast();
        test_io_timeout();
        test_loader_io();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
